// File: rtl/dmem_arbiter_if.sv
// Two-port data-memory arbiter bus: CPU port 0, loader/debug port 1, and the BRAM side.
// The arbiter takes the slave view; requesters and the BRAM model take the master view.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [31:0]       p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [31:0]       p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [31:0]       p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [31:0]       p1_rdata;

  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output bram_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  bram_we, bram_addr, bram_wdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  bram_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-BRAM arbiter: CPU port 0 has priority, bounded to CPU_BURST grants while port 1 waits.
// Combinational grant, one access per cycle, one-cycle read latency with MMIO reads returning 0.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CntW = ($clog2(CPU_BURST + 1) < 1) ? 1 : $clog2(CPU_BURST + 1);

  logic [CntW-1:0]   burst_q;
  logic              rd_valid_q;
  logic              rd_port_q;
  logic              rd_mmio_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              gnt0;
  logic              gnt1;
  logic              any_gnt;
  logic              sel_we;
  logic              sel_mmio;
  logic [ADDR_W-1:0] sel_word;
  logic [31:0]       sel_wdata;

  // Grants are forced low in reset so nothing reaches the BRAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (bus.p0_req && bus.p1_req) begin
        if (burst_q == CntW'(CPU_BURST)) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? bus.p1_we              : bus.p0_we;
    sel_mmio  = gnt1 ? bus.p1_addr[31]        : bus.p0_addr[31];
    sel_word  = gnt1 ? bus.p1_addr[ADDR_W+1:2] : bus.p0_addr[ADDR_W+1:2];
    sel_wdata = gnt1 ? bus.p1_wdata           : bus.p0_wdata;
  end

  assign bus.p0_gnt     = gnt0;
  assign bus.p1_gnt     = gnt1;
  assign bus.bram_addr  = any_gnt ? sel_word  : addr_q;
  assign bus.bram_wdata = any_gnt ? sel_wdata : wdata_q;
  assign bus.bram_we    = any_gnt & sel_we & ~sel_mmio;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_port_q  <= 1'b0;
      rd_mmio_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rd_valid_q <= any_gnt & ~sel_we;
      if (any_gnt) begin
        addr_q    <= sel_word;
        wdata_q   <= sel_wdata;
        rd_port_q <= gnt1;
        rd_mmio_q <= sel_mmio;
      end
      // Counts only CPU grants that made port 1 wait.
      if (!bus.p1_req || gnt1) begin
        burst_q <= '0;
      end else if (gnt0 && burst_q != CntW'(CPU_BURST)) begin
        burst_q <= burst_q + CntW'(1);
      end
    end
  end

  assign bus.p0_rvalid = rst_n & rd_valid_q & ~rd_port_q;
  assign bus.p1_rvalid = rst_n & rd_valid_q &  rd_port_q;
  assign bus.p0_rdata  = (bus.p0_rvalid && !rd_mmio_q) ? bus.bram_rdata : 32'h0;
  assign bus.p1_rdata  = (bus.p1_rvalid && !rd_mmio_q) ? bus.bram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a write-first registered BRAM model.
// Inputs change at the negedge; outputs are sampled 1 ns later within the same cycle.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  dmem_arbiter_if #(.ADDR_W(14)) bus ();

  dmem_arbiter #(
    .ADDR_W   (14),
    .CPU_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [16384];

  always @(posedge clk) begin
    if (bus.bram_we) begin
      mem[bus.bram_addr] <= bus.bram_wdata;
      bus.bram_rdata     <= bus.bram_wdata;
    end else begin
      bus.bram_rdata     <= mem[bus.bram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step(input logic rst, input logic r0, input logic w0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1,
                      input logic [31:0] a1, input logic [31:0] d1);
    @(negedge clk);
    rst_n        = rst;
    bus.p0_req   = r0;
    bus.p0_we    = w0;
    bus.p0_addr  = a0;
    bus.p0_wdata = d0;
    bus.p1_req   = r1;
    bus.p1_we    = w1;
    bus.p1_addr  = a1;
    bus.p1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic g1;
    logic prev;
    n_checks     = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.p0_req   = 1'b0;
    bus.p0_we    = 1'b0;
    bus.p0_addr  = 32'h0;
    bus.p0_wdata = 32'h0;
    bus.p1_req   = 1'b0;
    bus.p1_we    = 1'b0;
    bus.p1_addr  = 32'h0;
    bus.p1_wdata = 32'h0;

    // Reset with both ports requesting: everything quiet.
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("rst_p0_gnt", 32'(bus.p0_gnt), 32'h0);
    chk("rst_p1_gnt", 32'(bus.p1_gnt), 32'h0);
    chk("rst_bram_we", 32'(bus.bram_we), 32'h0);
    chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
    chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
    chk("rst_p0_rdata", bus.p0_rdata, 32'h0);
    chk("rst_p1_rdata", bus.p1_rdata, 32'h0);
    chk("rst_bram_addr", 32'(bus.bram_addr), 32'h0);
    chk("rst_bram_wdata", bus.bram_wdata, 32'h0);

    // Write then read 0x10 on port 0; first cycle out of reset arbitrates.
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr_p0_gnt", 32'(bus.p0_gnt), 32'h1);
    chk("wr_p1_gnt", 32'(bus.p1_gnt), 32'h0);
    chk("wr_bram_we", 32'(bus.bram_we), 32'h1);
    chk("wr_bram_addr", 32'(bus.bram_addr), 32'h4);
    chk("wr_bram_wdata", bus.bram_wdata, 32'hDEADBEEF);
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd_p0_gnt", 32'(bus.p0_gnt), 32'h1);
    chk("rd_bram_we", 32'(bus.bram_we), 32'h0);
    chk("rd_bram_addr", 32'(bus.bram_addr), 32'h4);
    chk("wr_no_rvalid", 32'(bus.p0_rvalid), 32'h0);
    idle();
    chk("rd_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
    chk("rd_p0_rdata", bus.p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
    chk("rd_p1_rdata", bus.p1_rdata, 32'h0);
    chk("idle_no_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'h0);
    chk("idle_addr_hold", 32'(bus.bram_addr), 32'h4);
    idle();
    chk("rvalid_one_cycle", 32'(bus.p0_rvalid), 32'h0);
    chk("rdata_zero_no_valid", bus.p0_rdata, 32'h0);

    // MMIO region: no BRAM write, reads return zero even over live data.
    step(1'b1, 1'b1, 1'b1, 32'h4, 32'h5555AAAA, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pre_mmio_we", 32'(bus.bram_we), 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80000008, 32'h1234);
    chk("mmio_wr_p1_gnt", 32'(bus.p1_gnt), 32'h1);
    chk("mmio_wr_p0_gnt", 32'(bus.p0_gnt), 32'h0);
    chk("mmio_wr_bram_we", 32'(bus.bram_we), 32'h0);
    chk("mmio_wr_addr", 32'(bus.bram_addr), 32'h2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80000004, 32'h0);
    chk("mmio_rd_p1_gnt", 32'(bus.p1_gnt), 32'h1);
    chk("mmio_rd_addr", 32'(bus.bram_addr), 32'h1);
    idle();
    chk("mmio_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
    chk("mmio_p1_rdata", bus.p1_rdata, 32'h0);
    chk("mmio_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);

    // Contention: p0 x4, p1, repeating; rvalid tracks the previous grant.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hCAFE0020);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      g1 = (i % 5) == 4;
      chk($sformatf("burst%0d_p0_gnt", i), 32'(bus.p0_gnt), 32'(!g1));
      chk($sformatf("burst%0d_p1_gnt", i), 32'(bus.p1_gnt), 32'(g1));
      if (i == 0) begin
        chk("burst0_no_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
      end else begin
        prev = ((i - 1) % 5) == 4;
        chk($sformatf("burst%0d_p0_rvalid", i), 32'(bus.p0_rvalid), 32'(!prev));
        chk($sformatf("burst%0d_p1_rvalid", i), 32'(bus.p1_rvalid), 32'(prev));
        if (prev) chk($sformatf("burst%0d_p1_rdata", i), bus.p1_rdata, 32'hCAFE0020);
        else      chk($sformatf("burst%0d_p0_rdata", i), bus.p0_rdata, 32'hDEADBEEF);
      end
    end
    idle();
    chk("burst_tail_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
    chk("burst_tail_p1_rdata", bus.p1_rdata, 32'hCAFE0020);
    chk("burst_tail_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);

    // Port 1 alone for a while must not pre-charge the burst counter.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("p1solo%0d_gnt", i), 32'({bus.p0_gnt, bus.p1_gnt}), 32'h1);
    end
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("join%0d_gnt", j), 32'({bus.p0_gnt, bus.p1_gnt}), (j == 4) ? 32'h1 : 32'h2);
    end
    idle();

    // Read granted just before reset must not surface afterwards.
    step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("prerst_p0_gnt", 32'(bus.p0_gnt), 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("inrst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'h0);
    chk("inrst_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
    chk("inrst_p0_rdata", bus.p0_rdata, 32'h0);
    chk("inrst_bram_we", 32'(bus.bram_we), 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("inrst2_bram_addr", 32'(bus.bram_addr), 32'h0);
    chk("inrst2_bram_wdata", bus.bram_wdata, 32'h0);
    chk("inrst2_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40, 32'h77, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("postrst_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'h2);
    chk("postrst_bram_we", 32'(bus.bram_we), 32'h1);
    chk("postrst_bram_addr", 32'(bus.bram_addr), 32'h10);
    chk("postrst_rvalid", 32'({bus.p0_rvalid, bus.p1_rvalid}), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("postrst_rd_gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'h2);
    idle();
    chk("postrst_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
    chk("postrst_p0_rdata", bus.p0_rdata, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning the BRAM word-address width, taken from request address bits [ADDR_W+1:2].
REQ-002 SHALL have parameter CPU_BURST, default 4, meaning the maximum number of consecutive port-0 grants while port 1 is requesting.
REQ-003 clk  input  1  single clock; all state changes on the posedge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 p0_req  input  1  port 0 (CPU data side) access request.
REQ-006 p0_we  input  1  port 0 write enable, qualified by p0_req.
REQ-007 p0_addr  input  32  port 0 byte address.
REQ-008 p0_wdata  input  32  port 0 write data.
REQ-009 p0_gnt  output  1  port 0 request accepted this cycle.
REQ-010 p0_rvalid  output  1  port 0 read data valid.
REQ-011 p0_rdata  output  32  port 0 read data.
REQ-012 p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  SHALL have the same widths and meanings for port 1 (loader/debug side).
REQ-013 bram_we  output  1  BRAM write enable.
REQ-014 bram_addr  output  ADDR_W  BRAM word address.
REQ-015 bram_wdata  output  32  BRAM write data.
REQ-016 bram_rdata  input  32  BRAM read data, valid one cycle after the address is presented.

Function
REQ-017 Grant decision SHALL be combinational in the request cycle: p0_gnt/p1_gnt one-hot or zero, never both high.
REQ-018 Only p0_req: grant p0. Only p1_req: grant p1. Neither: no grant, bram_we=0.
REQ-019 Both requesting: grant p0 unless burst counter == CPU_BURST, then grant p1.
REQ-020 Burst counter (width clog2(CPU_BURST+1)): increments on a p0 grant while p1_req=1; clears on any p1 grant or on any cycle with p1_req=0; saturates at CPU_BURST.
REQ-021 Granted port's address/wdata/we SHALL drive bram_addr/bram_wdata in the same cycle; with no grant, bram_addr/bram_wdata hold their last driven values.
REQ-022 bram_we = granted we AND NOT addr[31]; addr[31]=1 (MMIO region) SHALL never write BRAM.
REQ-023 Read pipeline register (valid, port id, mmio flag) SHALL capture every granted read (we=0).
REQ-024 Cycle after a granted read: the owning port's rvalid=1 for exactly one cycle; rdata = bram_rdata, or 32'h0 if the captured mmio flag is set.
REQ-025 Non-owning port: rvalid=0; its rdata SHALL be 32'h0 whenever its rvalid=0.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 Back-to-back grants SHALL be accepted every cycle; throughput one access per cycle; read latency exactly 1.
REQ-028 A read to address A granted in the same cycle as an earlier write to A SHALL return the BRAM's registered data (write-first behaviour of the BRAM); the arbiter adds no bypass.
REQ-029 Port requests are not held internally: an ungranted port SHALL keep req and its fields stable until granted.

Reset
REQ-030 On rst_n=0 at a posedge: burst counter=0, read pipeline valid=0, bram_addr=0, bram_wdata=0.
REQ-031 While rst_n=0: p0_gnt=p1_gnt=0, bram_we=0, p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
REQ-032 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset.
REQ-033 The first cycle with rst_n=1 SHALL arbitrate normally.

Verification
REQ-034 p0 write 0x0000_0010 data 0xDEADBEEF, then p0 read 0x0000_0010 -> p0_gnt both cycles; bram_addr=4; p0_rvalid one cycle later with p0_rdata=0xDEADBEEF; p1_rvalid=0.
REQ-035 p0 and p1 request continuously (reads), CPU_BURST=4 -> grant pattern p0,p0,p0,p0,p1 repeating; rvalid follows each grant by one cycle to the correct port.
REQ-036 p1 write to 0x8000_0008 data 0x1234 -> p1_gnt=1, bram_we=0; p1 read 0x8000_0004 -> p1_rvalid=1 next cycle, p1_rdata=0.
REQ-037 p1 alone requesting for 10 cycles, then p0 joins -> p0 granted immediately; counter starts at 0.
REQ-038 p0 read granted, rst_n=0 the next posedge -> no rvalid on either port; all outputs at reset values; first cycle after release arbitrates.
REQ-039 Random p0/p1 req/we/addr, 10k cycles, vs. reference model -> never dual grant, no port waits more than CPU_BURST+1 cycles, all rdata matches model memory.
